// File: rtl/nav_cmd_arb.sv
// nav_cmd_arb -- navigation command arbiter
//
// Arbitrates N_SRC command sources onto the single navigate/PID command path.
// Start strobes are captured into a one-deep pending slot per source; only the
// source picked by src_sel is served. The granted source owns the path from
// grant until mv_cmplt (or a move timeout). The desired heading and its start
// strobe travel through a matched register pipeline so they reach the outputs
// together.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   src_sel         index of the source allowed to start a new command
//   dsrd_hdng_in    per-source heading, source i at [i*HDNG_W +: HDNG_W]
//   strt_hdng_in    per-source heading-start pulse
//   strt_mv_in      per-source move-start pulse
//   stp_lft_in      per-source stop-at-left-opening level
//   stp_rght_in     per-source stop-at-right-opening level
//   mv_cmplt        move-complete pulse from navigate
//   dsrd_hdng_out   heading to IR_math/PID (holds its last value when idle)
//   strt_hdng       one-cycle heading start, aligned with dsrd_hdng_out
//   strt_mv         one-cycle move start, aligned with dsrd_hdng_out
//   stp_lft         owner's stp_lft_in, registered, 0 when idle
//   stp_rght        owner's stp_rght_in, registered, 0 when idle
//   mv_cmplt_out    mv_cmplt (or timeout) routed to the owning source only
//   busy            a command is being issued or a move is in progress
//   to_err          sticky move-timeout flag, cleared only by rst
module nav_cmd_arb #(
  parameter int              N_SRC       = 2,
  parameter int              HDNG_W      = 12,
  parameter int              PIPE_STAGES = 1,
  parameter int              TO_W        = 20,
  parameter logic [TO_W-1:0] TO_CYC      = 20'hF_FFFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(N_SRC)-1:0]   src_sel,
  input  logic [N_SRC*HDNG_W-1:0]    dsrd_hdng_in,
  input  logic [N_SRC-1:0]           strt_hdng_in,
  input  logic [N_SRC-1:0]           strt_mv_in,
  input  logic [N_SRC-1:0]           stp_lft_in,
  input  logic [N_SRC-1:0]           stp_rght_in,
  input  logic                       mv_cmplt,
  output logic [HDNG_W-1:0]          dsrd_hdng_out,
  output logic                       strt_hdng,
  output logic                       strt_mv,
  output logic                       stp_lft,
  output logic                       stp_rght,
  output logic [N_SRC-1:0]           mv_cmplt_out,
  output logic                       busy,
  output logic                       to_err
);

  localparam int SEL_W = $clog2(N_SRC);
  // Per-source vectors are zero-padded to 2**SEL_W so any src_sel value
  // indexes in range; unused indices read as "nothing pending".
  localparam int N_PAD = 1 << SEL_W;
  localparam logic [TO_W-1:0] TO_LAST = TO_CYC - TO_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_e;

  state_e                  state_q, state_d;
  logic [SEL_W-1:0]        owner_q, owner_d;
  logic [SEL_W-1:0]        src_sel_q;
  logic [N_SRC-1:0]        hdng_pend_q, hdng_pend_d;
  logic [N_SRC-1:0]        mv_pend_q, mv_pend_d;
  logic [HDNG_W-1:0]       hdng_val_q [N_SRC];
  logic [HDNG_W-1:0]       hdng_val_d [N_SRC];
  // Stage 0 is the launch register; stage PIPE_STAGES drives the outputs.
  // Strobe bits are {heading, move}.
  logic [HDNG_W-1:0]       pipe_hdng_q [PIPE_STAGES+1];
  logic [1:0]              pipe_strb_q [PIPE_STAGES+1];
  logic [HDNG_W-1:0]       launch_hdng_d;
  logic [1:0]              launch_strb_d;
  logic [TO_W-1:0]         timer_q, timer_d;
  logic                    to_err_q, to_err_d;
  logic                    stp_lft_q, stp_lft_d;
  logic                    stp_rght_q, stp_rght_d;
  logic [N_SRC-1:0]        mv_cmplt_out_q, mv_cmplt_out_d;

  logic [N_PAD-1:0]        hdng_live, mv_live, stp_lft_pad, stp_rght_pad, mco_pad;
  logic [HDNG_W-1:0]       hdng_eff [N_PAD];
  logic                    grant_hdng, grant_mv, sel_chg;

  // Live strobes are merged with the stored slots so an IDLE grant can use a
  // strobe in the very cycle it arrives.
  always_comb begin
    hdng_live    = N_PAD'(hdng_pend_q | strt_hdng_in);
    mv_live      = N_PAD'(mv_pend_q | strt_mv_in);
    stp_lft_pad  = N_PAD'(stp_lft_in);
    stp_rght_pad = N_PAD'(stp_rght_in);
    for (int i = 0; i < N_PAD; i++) hdng_eff[i] = '0;
    for (int i = 0; i < N_SRC; i++) begin
      hdng_eff[i] = (strt_hdng_in[i] | strt_mv_in[i]) ?
                    dsrd_hdng_in[i*HDNG_W +: HDNG_W] : hdng_val_q[i];
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    grant_hdng = 1'b0;
    grant_mv   = 1'b0;
    timer_d    = '0;
    to_err_d   = to_err_q;
    mco_pad    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (hdng_live[src_sel])    grant_hdng = 1'b1;
        else if (mv_live[src_sel]) grant_mv   = 1'b1;
        if (grant_hdng || grant_mv) begin
          owner_d = src_sel;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Leave once the strobe is visible on the outputs.
        if (|pipe_strb_q[PIPE_STAGES]) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (mv_cmplt) begin
          mco_pad[owner_q] = 1'b1;
          state_d          = S_IDLE;
        end else if (timer_q == TO_LAST) begin
          to_err_d         = 1'b1;
          mco_pad[owner_q] = 1'b1;
          state_d          = S_IDLE;
        end else begin
          timer_d = timer_q + TO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    mv_cmplt_out_d = mco_pad[N_SRC-1:0];
    stp_lft_d      = (state_d != S_IDLE) ? stp_lft_pad[owner_d]  : 1'b0;
    stp_rght_d     = (state_d != S_IDLE) ? stp_rght_pad[owner_d] : 1'b0;
    launch_hdng_d  = (grant_hdng || grant_mv) ? hdng_eff[src_sel] : pipe_hdng_q[0];
    launch_strb_d  = {grant_hdng, grant_mv};
  end

  // Slot update: capture, flush of non-selected sources on a src_sel change,
  // and clearing of the flag just served.
  assign sel_chg = (src_sel != src_sel_q);

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      hdng_pend_d[i] = hdng_live[i];
      mv_pend_d[i]   = mv_live[i];
      hdng_val_d[i]  = hdng_eff[i];
      if (sel_chg && (SEL_W'(i) != src_sel)) begin
        hdng_pend_d[i] = 1'b0;
        mv_pend_d[i]   = 1'b0;
        hdng_val_d[i]  = '0;
      end
      if (SEL_W'(i) == src_sel) begin
        if (grant_hdng) hdng_pend_d[i] = 1'b0;
        if (grant_mv)   mv_pend_d[i]   = 1'b0;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      owner_q        <= '0;
      src_sel_q      <= '0;
      hdng_pend_q    <= '0;
      mv_pend_q      <= '0;
      timer_q        <= '0;
      to_err_q       <= 1'b0;
      stp_lft_q      <= 1'b0;
      stp_rght_q     <= 1'b0;
      mv_cmplt_out_q <= '0;
      // NOTE: these arrays are small register banks, not RAM, so clearing
      // them in reset costs nothing and keeps stale strobes from escaping.
      for (int i = 0; i < N_SRC; i++) hdng_val_q[i] <= '0;
      for (int s = 0; s <= PIPE_STAGES; s++) begin
        pipe_hdng_q[s] <= '0;
        pipe_strb_q[s] <= '0;
      end
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      src_sel_q      <= src_sel;
      hdng_pend_q    <= hdng_pend_d;
      mv_pend_q      <= mv_pend_d;
      timer_q        <= timer_d;
      to_err_q       <= to_err_d;
      stp_lft_q      <= stp_lft_d;
      stp_rght_q     <= stp_rght_d;
      mv_cmplt_out_q <= mv_cmplt_out_d;
      for (int i = 0; i < N_SRC; i++) hdng_val_q[i] <= hdng_val_d[i];
      pipe_hdng_q[0] <= launch_hdng_d;
      pipe_strb_q[0] <= launch_strb_d;
      for (int s = 1; s <= PIPE_STAGES; s++) begin
        pipe_hdng_q[s] <= pipe_hdng_q[s-1];
        pipe_strb_q[s] <= pipe_strb_q[s-1];
      end
    end
  end

  assign dsrd_hdng_out = pipe_hdng_q[PIPE_STAGES];
  assign strt_hdng     = pipe_strb_q[PIPE_STAGES][1];
  assign strt_mv       = pipe_strb_q[PIPE_STAGES][0];
  assign stp_lft       = stp_lft_q;
  assign stp_rght      = stp_rght_q;
  assign mv_cmplt_out  = mv_cmplt_out_q;
  assign busy          = (state_q != S_IDLE);
  assign to_err        = to_err_q;

endmodule
